// File: rtl/mode_counter.sv
// mode_counter: programmable-terminal counter with four counting modes,
// synchronous load, registered terminal pulse and terminal-event counter.
module mode_counter #(
  parameter int WIDTH = 4,
  parameter int EVT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic [WIDTH-1:0] max_val,
  input  logic [1:0]       mode,
  output logic [WIDTH-1:0] out,
  output logic             dir,
  output logic             tc,
  output logic [EVT_W-1:0] evt_cnt
);

  typedef enum logic [1:0] {
    M_UP_WRAP = 2'b00,
    M_DN_WRAP = 2'b01,
    M_UP_SAT  = 2'b10,
    M_PING    = 2'b11
  } mode_e;

  localparam logic [WIDTH-1:0] ONE  = WIDTH'(1);
  localparam logic [WIDTH-1:0] ZERO = '0;

  logic [WIDTH-1:0] out_q, out_d;
  logic             dir_q, dir_d;
  logic             tc_q;
  logic [EVT_W-1:0] evt_q;
  logic             term_d;
  logic [WIDTH-1:0] ld_val;
  mode_e            mode_s;

  assign mode_s = mode_e'(mode);

  // Loads are clamped into the legal range 0..max_val.
  assign ld_val = (load_val > max_val) ? max_val : load_val;

  // Next-step value, direction and terminal flag for an enabled cycle.
  always_comb begin
    out_d  = out_q;
    dir_d  = dir_q;
    term_d = 1'b0;
    unique case (mode_s)
      M_UP_WRAP: begin
        dir_d = 1'b0;
        if (out_q >= max_val) begin
          out_d  = ZERO;
          term_d = 1'b1;
        end else begin
          out_d = out_q + ONE;
        end
      end
      M_DN_WRAP: begin
        dir_d = 1'b1;
        if (out_q == ZERO || out_q > max_val) begin
          out_d  = max_val;
          term_d = 1'b1;
        end else begin
          out_d = out_q - ONE;
        end
      end
      M_UP_SAT: begin
        dir_d = 1'b0;
        if (out_q >= max_val) begin
          out_d  = max_val;
          term_d = 1'b1;
        end else begin
          out_d = out_q + ONE;
        end
      end
      M_PING: begin
        // Ordering matters: an out-of-range value and the degenerate
        // max_val==0 case must be caught before the max_val-1 turn.
        if (out_q > max_val) begin
          out_d  = max_val;
          dir_d  = 1'b1;
          term_d = 1'b1;
        end else if (max_val == ZERO) begin
          out_d  = ZERO;
          dir_d  = ~dir_q;
          term_d = 1'b1;
        end else if (!dir_q && out_q == max_val) begin
          out_d  = max_val - ONE;
          dir_d  = 1'b1;
          term_d = 1'b1;
        end else if (dir_q && out_q == ZERO) begin
          out_d  = ONE;
          dir_d  = 1'b0;
          term_d = 1'b1;
        end else if (dir_q) begin
          out_d = out_q - ONE;
        end else begin
          out_d = out_q + ONE;
        end
      end
      default: begin
        out_d  = out_q;
        dir_d  = dir_q;
        term_d = 1'b0;
      end
    endcase
  end

  // State update: reset beats load, load beats enable, otherwise hold.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_q <= '0;
      dir_q <= 1'b0;
      tc_q  <= 1'b0;
      evt_q <= '0;
    end else if (load) begin
      out_q <= ld_val;
      dir_q <= 1'b0;
      tc_q  <= 1'b0;
    end else if (en) begin
      out_q <= out_d;
      dir_q <= dir_d;
      tc_q  <= term_d;
      if (term_d) begin
        evt_q <= evt_q + EVT_W'(1);
      end
    end else begin
      tc_q <= 1'b0;
    end
  end

  assign out     = out_q;
  assign dir     = dir_q;
  assign tc      = tc_q;
  assign evt_cnt = evt_q;

endmodule
